// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decrypt sequencing controller.
//   state_t     : controller FSM states
//   round_t     : 4-bit round index
//   NR_AES128   : number of AES-128 rounds
//   ROUND_LAST  : highest legal round index (NR_AES128-1)
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [3:0] round_t;

  localparam round_t ROUND_LAST = 4'(NR_AES128 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    ROUND  = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Loadable up/down round counter with terminal-count flag.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : load load_val_i this cycle (wins over counting)
//   load_val_i   : value to load
//   en_i         : advance one step in the direction given by up_i
//   up_i         : 1 = count up, terminal at ROUND_LAST; 0 = count down, terminal at 0
//   cnt_o        : current count
//   tc_o         : count has reached the terminal value for the current direction
module aes_round_counter
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  round_t load_val_i,
  input  logic   en_i,
  input  logic   up_i,
  output round_t cnt_o,
  output logic   tc_o
);

  round_t cnt_q, cnt_d;

  assign tc_o  = up_i ? (cnt_q == ROUND_LAST) : (cnt_q == '0);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > ROUND_LAST) begin
      // Out-of-range index (e.g. upset) snaps back to a legal value.
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = up_i ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_dec_controller.sv
// Sequencing controller for the multicycle AES-128 inverse cipher.
// Optional feature macro: AES_DEC_KEY_CACHE_EN (last-round-key cache; when
// undefined every transaction runs the forward expansion pass).
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : ciphertext/key valid        in_ready    : can accept input
//   key_new     : key changed since last txn  load_input  : datapath captures input
//   expand_en   : forward key-expansion step  key_dir     : 0 fwd, 1 inverse
//   save_key    : store last round key        round       : round index
//   final_round : last round (no InvMixCol)   out_valid   : plaintext valid
//   out_ready   : downstream accepts plaintext
//
// state  | meaning
// IDLE   | waiting for a ciphertext/key pair
// EXPAND | forward key expansion, round counts 0..NR-1
// ROUND  | inverse rounds, round counts NR-1..0
// HOLD   | plaintext presented until out_ready
module aes_dec_controller
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       key_new,
  output logic       in_ready,
  output logic       load_input,
  output logic       expand_en,
  output logic       key_dir,
  output logic       save_key,
  output logic [3:0] round,
  output logic       final_round,
  output logic       out_valid,
  input  logic       out_ready
);

  state_t state_q, state_d;
  round_t cnt, cnt_val;
  logic   cnt_tc, cnt_load, cnt_en, cnt_up;
  logic   cache_hit, cache_set, save_pulse;

  assign cnt_up = (state_q == EXPAND);

  aes_round_counter u_round_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .up_i       (cnt_up),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  assign round = cnt;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cache_vld_q <= 1'b0;
    else if (cache_set) cache_vld_q <= 1'b1;
  end

  assign cache_hit = cache_vld_q & ~key_new;
  assign save_key  = save_pulse;
`else
  logic [2:0] unused_cache;
  assign unused_cache = {key_new, cache_set, save_pulse};
  assign cache_hit    = 1'b0;
  assign save_key     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_en      = 1'b0;
    cache_set   = 1'b0;
    save_pulse  = 1'b0;
    in_ready    = 1'b0;
    expand_en   = 1'b0;
    key_dir     = 1'b0;
    final_round = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      EXPAND: begin
        expand_en = 1'b1;
        if (cnt_tc) begin
          save_pulse = 1'b1;
          cache_set  = 1'b1;
          state_d    = ROUND;
          cnt_load   = 1'b1;
          cnt_val    = ROUND_LAST;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ROUND: begin
        key_dir = 1'b1;
        if (cnt_tc) begin
          final_round = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
    endcase

    load_input = in_valid & in_ready;

    // Accept from IDLE or from HOLD (no bubble); overrides the HOLD->IDLE step.
    if (load_input) begin
      cnt_load = 1'b1;
      if (cache_hit) begin
        state_d = ROUND;
        cnt_val = ROUND_LAST;
      end else begin
        state_d = EXPAND;
        cnt_val = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_aes_dec_controller.sv
module tb_aes_dec_controller;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic       clk, rst_n, in_valid, key_new, out_ready;
  logic       in_ready, load_input, expand_en, key_dir, save_key, final_round, out_valid;
  logic [3:0] round;

  int errors = 0;
  int checks = 0;
  bit cache_model = 1'b0;

  aes_dec_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .key_new     (key_new),
    .in_ready    (in_ready),
    .load_input  (load_input),
    .expand_en   (expand_en),
    .key_dir     (key_dir),
    .save_key    (save_key),
    .round       (round),
    .final_round (final_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {expand_en, key_dir, save_key, final_round, out_valid, in_ready, load_input, round[3:0]}
  function automatic logic [10:0] obs();
    return {expand_en, key_dir, save_key, final_round, out_valid, in_ready, load_input, round};
  endfunction

  function automatic logic [10:0] mk(bit ex, bit kd, bit sv, bit fr, bit ov, bit ir, bit ld,
                                     int rnd);
    logic [3:0] r;
    r = 4'(rnd);
    return {ex, kd, sv, fr, ov, ir, ld, r};
  endfunction

  localparam logic [10:0] IDLE_VEC = 11'b00000100000;
  localparam logic [10:0] HOLD_VEC = 11'b00001000000;

  // Expected observation in cycle c after accept (c=1 is the first cycle after the accept edge).
  function automatic logic [10:0] exp_vec(bit hit, int c);
    if (hit) begin
      if (c <= 10) return mk(0, 1, 0, c == 10, 0, 0, 0, 10 - c);
      return HOLD_VEC;
    end
    if (c <= 10) return mk(1, 0, CACHE && (c == 10), 0, 0, 0, 0, c - 1);
    if (c <= 20) return mk(0, 1, 0, c == 20, 0, 0, 0, 20 - c);
    return HOLD_VEC;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit calc_hit(bit kn);
    return CACHE && !kn && cache_model;
  endfunction

  task automatic accept(input bit kn);
    in_valid = 1'b1;
    key_new  = kn;
    #1;
    check("accept_handshake", {14'd0, in_ready, load_input}, 16'h0003);
    @(posedge clk); #1;
    in_valid = 1'b0;
    key_new  = 1'b0;
  endtask

  // Checks cycles 1..upto after accept; ends inside cycle upto without stepping past it.
  task automatic track(input bit hit, input bit pulse, input int upto);
    for (int c = 1; c <= upto; c++) begin
      in_valid = pulse && (c == 3);
      #1;
      check($sformatf("cycle%0d_hit%0d", c, hit), {5'd0, obs()}, {5'd0, exp_vec(hit, c)});
      if (c < upto) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    #1;
    check("release_ready", {15'd0, in_ready}, 16'h0001);
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    check("back_to_idle", {5'd0, obs()}, {5'd0, IDLE_VEC});
  endtask

  typedef struct {
    bit kn;
    bit pulse;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit hit;
    int lat;

    vecs[0] = '{kn: 1'b1, pulse: 1'b0};
    vecs[1] = '{kn: 1'b0, pulse: 1'b0};
    vecs[2] = '{kn: 1'b0, pulse: 1'b1};
    vecs[3] = '{kn: 1'b1, pulse: 1'b1};
    vecs[4] = '{kn: 1'b0, pulse: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; key_new = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_outputs", {5'd0, obs()}, {5'd0, IDLE_VEC});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("after_reset", {5'd0, obs()}, {5'd0, IDLE_VEC});

    foreach (vecs[i]) begin
      hit = calc_hit(vecs[i].kn);
      lat = hit ? 11 : 21;
      accept(vecs[i].kn);
      track(hit, vecs[i].pulse, lat);
      cache_model = CACHE;
      release_out();
    end

    // HOLD stall for 5 cycles, then release with a simultaneous accept.
    hit = calc_hit(1'b0);
    accept(1'b0);
    track(hit, 1'b0, hit ? 11 : 21);
    cache_model = CACHE;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check($sformatf("hold_stall%0d", s), {5'd0, obs()}, {5'd0, HOLD_VEC});
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    key_new   = 1'b0;
    #1;
    check("b2b_accept", {13'd0, in_ready, load_input, out_valid}, 16'h0007);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hit = calc_hit(1'b0);
    track(hit, 1'b0, hit ? 11 : 21);
    release_out();

    // Reset in ROUND at round 4, then key_new=0 must still expand.
    accept(1'b1);
    track(1'b0, 1'b0, 16);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {5'd0, obs()}, {5'd0, IDLE_VEC});
    cache_model = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrun_reset_release", {5'd0, obs()}, {5'd0, IDLE_VEC});
    hit = calc_hit(1'b0);
    check("post_reset_no_hit", {15'd0, hit}, 16'h0000);
    accept(1'b0);
    track(1'b0, 1'b0, 21);
    cache_model = CACHE;
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
